// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle datapath control sequencer; define MC_CTRL_PERF_EN for instr_cnt/cycle_cnt counters
module mc_ctrl_fsm #(
  parameter int MAX_WAIT = 255,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       aluzero,
  input  logic       mem_ack,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] pc_src,
  output logic       irwrite,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [3:0] aluctrl,
  output logic       ra_en,
  output logic       mdr_en,
  output logic       regw,
  output logic       memtoreg,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       mem_err,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] cycle_cnt
`endif
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, BAD} state_t;
  state_t cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic is_ld, is_st, timeout, unused_ok;
  assign is_ld = opcode == 4'b0001;
  assign is_st = opcode == 4'b0011;
  assign timeout = cur == MEM && !mem_ack && wait_cnt == CW'(MAX_WAIT - 1);
  assign state = cur;
  assign unused_ok = aluzero;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur <= IDLE;
      wait_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      cur <= nxt;
      wait_cnt <= (cur == MEM && nxt == MEM) ? wait_cnt + 1'b1 : '0;
      if (timeout) mem_err <= 1'b1;
    end
  always_comb begin
    nxt = cur;
    pcwrite = 1'b0;
    pcwritecond = 1'b0;
    pc_src = 2'b00;
    irwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 3'b000;
    aluctrl = 4'b0000;
    ra_en = 1'b0;
    mdr_en = 1'b0;
    regw = 1'b0;
    memtoreg = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    halted = 1'b0;
    if (rst)
      case (cur)
        IDLE: if (start) begin
          pcwrite = 1'b1;
          pc_src = 2'b10;
          nxt = FETCH;
        end
        FETCH: begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          alusrcb = 3'b001;
          aluctrl = 4'b1000;
          nxt = DECODE;
        end
        DECODE: begin
          aluctrl = 4'b1000;
          ra_en = 1'b1;
          alusrcb = opcode == 4'b0101 ? 3'b110 : 3'b011;
          nxt = opcode == HALT_OPC ? HALT : EXEC;
        end
        EXEC:
          if (opcode == 4'b0101) begin
            pcwrite = 1'b1;
            pc_src = 2'b01;
            nxt = FETCH;
          end else if (opcode == 4'b0100) begin
            alusrca = 1'b1;
            aluctrl = 4'b1001;
            pcwritecond = 1'b1;
            pc_src = 2'b01;
            nxt = FETCH;
          end else if (is_ld || is_st) begin
            alusrca = 1'b1;
            alusrcb = 3'b010;
            aluctrl = 4'b1000;
            ra_en = 1'b1;
            nxt = MEM;
          end else begin
            alusrca = 1'b1;
            aluctrl = opcode;
            ra_en = 1'b1;
            alusrcb = opcode == 4'b1100 ? 3'b100 :
                      (opcode == 4'b1101 || opcode == 4'b1110) ? 3'b101 : 3'b000;
            nxt = WB;
          end
        MEM: begin
          mem_req = 1'b1;
          mem_we = is_st;
          mdr_en = is_ld && mem_ack;
          nxt = mem_ack ? (is_ld ? WB : FETCH) : timeout ? HALT : MEM;
        end
        WB: begin
          regw = 1'b1;
          memtoreg = is_ld;
          nxt = FETCH;
        end
        HALT: halted = 1'b1;
        default: nxt = IDLE;
      endcase
  end
`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (cur == FETCH) instr_cnt <= instr_cnt + 32'd1;
      if (cur != IDLE && cur != HALT) cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed checks of the control sequencer outputs per state
module tb_mc_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, aluzero = 1'b0, mem_ack = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic pcwrite, pcwritecond, irwrite, alusrca, ra_en, mdr_en, regw, memtoreg;
  logic mem_req, mem_we, halted, mem_err;
  logic [1:0] pc_src;
  logic [2:0] alusrcb, state;
  logic [3:0] aluctrl;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt, cycle_cnt;
`endif
  int errors = 0, checks = 0;
  logic [23:0] ctl;
  always #5 clk = ~clk;
  mc_ctrl_fsm #(.MAX_WAIT(4), .HALT_OPC(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .aluzero(aluzero), .mem_ack(mem_ack),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pc_src(pc_src), .irwrite(irwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluctrl(aluctrl), .ra_en(ra_en), .mdr_en(mdr_en),
    .regw(regw), .memtoreg(memtoreg), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .mem_err(mem_err), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
`endif
  );
  // state | pcw pcwc pc_src irw srca srcb aluctrl | ra_en mdr_en regw memtoreg mem_req mem_we halted mem_err
  assign ctl = {state, pcwrite, pcwritecond, pc_src, irwrite, alusrca, alusrcb, aluctrl,
                ra_en, mdr_en, regw, memtoreg, mem_req, mem_we, halted, mem_err};
  localparam logic [23:0] ZERO   = 24'b000_0_0_00_0_0_000_0000_0_0_0_0_0_0_0_0;
  localparam logic [23:0] IDLE_S = 24'b000_1_0_10_0_0_000_0000_0_0_0_0_0_0_0_0;
  localparam logic [23:0] FETCH  = 24'b001_1_0_00_1_0_001_1000_0_0_0_0_0_0_0_0;
  localparam logic [23:0] DEC    = 24'b010_0_0_00_0_0_011_1000_1_0_0_0_0_0_0_0;
  localparam logic [23:0] DEC_J  = 24'b010_0_0_00_0_0_110_1000_1_0_0_0_0_0_0_0;
  localparam logic [23:0] EX_ADD = 24'b011_0_0_00_0_1_000_1000_1_0_0_0_0_0_0_0;
  localparam logic [23:0] EX_D   = 24'b011_0_0_00_0_1_101_1101_1_0_0_0_0_0_0_0;
  localparam logic [23:0] EX_MEM = 24'b011_0_0_00_0_1_010_1000_1_0_0_0_0_0_0_0;
  localparam logic [23:0] EX_BEQ = 24'b011_0_1_01_0_1_000_1001_0_0_0_0_0_0_0_0;
  localparam logic [23:0] EX_JMP = 24'b011_1_0_01_0_0_000_0000_0_0_0_0_0_0_0_0;
  localparam logic [23:0] MEM_LD = 24'b100_0_0_00_0_0_000_0000_0_0_0_0_1_0_0_0;
  localparam logic [23:0] MEM_LA = 24'b100_0_0_00_0_0_000_0000_0_1_0_0_1_0_0_0;
  localparam logic [23:0] MEM_ST = 24'b100_0_0_00_0_0_000_0000_0_0_0_0_1_1_0_0;
  localparam logic [23:0] WB_ALU = 24'b101_0_0_00_0_0_000_0000_0_0_1_0_0_0_0_0;
  localparam logic [23:0] WB_LD  = 24'b101_0_0_00_0_0_000_0000_0_0_1_1_0_0_0_0;
  localparam logic [23:0] HLT_E  = 24'b110_0_0_00_0_0_000_0000_0_0_0_0_0_0_1_1;
  localparam logic [23:0] HLT    = 24'b110_0_0_00_0_0_000_0000_0_0_0_0_0_0_1_0;
  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic launch();
    start = 1'b1;
    #1;
    check("idle_start", ctl, IDLE_S);
    step();
    start = 1'b0;
    #1;
    check("fetch", ctl, FETCH);
  endtask
  initial begin
    start = 1'b1;
    repeat (2) step();
    check("reset", ctl, ZERO);
    start = 1'b0;
    rst = 1'b1;
    step();
    check("idle", ctl, ZERO);
    launch();
    opcode = 4'b1000;
    step(); check("add_dec", ctl, DEC);
    step(); check("add_exec", ctl, EX_ADD);
    step(); check("add_wb", ctl, WB_ALU);
    step(); check("add_fetch", ctl, FETCH);
    opcode = 4'b0001;
    step(); check("ld_dec", ctl, DEC);
    step(); check("ld_exec", ctl, EX_MEM);
    step(); check("ld_mem1", ctl, MEM_LD);
    step(); check("ld_mem2", ctl, MEM_LD);
    step(); check("ld_mem3", ctl, MEM_LD);
    step(); mem_ack = 1'b1; #1; check("ld_mem_ack", ctl, MEM_LA);
    step(); mem_ack = 1'b0; #1; check("ld_wb", ctl, WB_LD);
    step(); check("ld_fetch", ctl, FETCH);
    opcode = 4'b0011;
    step(); check("st_dec", ctl, DEC);
    step(); check("st_exec", ctl, EX_MEM);
    step(); mem_ack = 1'b1; #1; check("st_mem", ctl, MEM_ST);
    step(); mem_ack = 1'b0; #1; check("st_fetch", ctl, FETCH);
    opcode = 4'b0100;
    for (int z = 1; z >= 0; z--) begin
      aluzero = z[0];
      step(); check("beq_dec", ctl, DEC);
      step(); check("beq_exec", ctl, EX_BEQ);
      step(); check("beq_fetch", ctl, FETCH);
    end
    opcode = 4'b0101;
    step(); check("jmp_dec", ctl, DEC_J);
    step(); check("jmp_exec", ctl, EX_JMP);
    step(); check("jmp_fetch", ctl, FETCH);
    opcode = 4'b1101;
    step(); check("op_d_dec", ctl, DEC);
    step(); check("op_d_exec", ctl, EX_D);
    step(); check("op_d_wb", ctl, WB_ALU);
    step(); check("op_d_fetch", ctl, FETCH);
    opcode = 4'b0001;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step(); check("to_mem", ctl, MEM_LD);
    end
    step(); check("timeout_halt", ctl, HLT_E);
    start = 1'b1;
    step(); check("halt_start_ign", ctl, HLT_E);
    start = 1'b0;
    rst = 1'b0; #1; check("halt_reset", ctl, ZERO);
    step(); rst = 1'b1; step();
    launch();
    opcode = 4'b0011;
    step(); step();
    step(); check("st_wait", ctl, MEM_ST);
    #2 rst = 1'b0; #1; check("mid_mem_reset", ctl, ZERO);
    step(); rst = 1'b1; step();
    launch();
    opcode = 4'hF;
    step(); check("halt_dec", ctl, DEC);
    step(); check("halt_opc", ctl, HLT);
    step(); check("halt_stay", ctl, HLT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
